// File: rtl/rod_ctrl_pkg.sv
// rtl/rod_ctrl_pkg.sv - shared types, widths and Y clamp helper for the rod motion controller
package rod_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
    DOWN  = 2'd2,
    BRAKE = 2'd3
  } rod_state_t;

  localparam int SPEED_W = 4;
  localparam int Y_W     = 11;

  typedef struct packed {
    logic signed [10:0] y;
    logic               hit;
  } clamp_t;

  // Saturate a widened Y candidate to [min_y, max_y]; hit flags that a limit was crossed.
  function automatic clamp_t clamp_y(input logic signed [11:0] y_in,
                                     input logic signed [11:0] min_y,
                                     input logic signed [11:0] max_y);
    clamp_t r;
    if (y_in < min_y) begin
      r.y   = min_y[10:0];
      r.hit = 1'b1;
    end else if (y_in > max_y) begin
      r.y   = max_y[10:0];
      r.hit = 1'b1;
    end else begin
      r.y   = y_in[10:0];
      r.hit = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/rod_motion_ctrl.sv
// rtl/rod_motion_ctrl.sv - per-frame accelerate/brake vertical motion controller for one rod
module rod_motion_ctrl #(
  parameter int INIT_Y       = 200,
  parameter int MIN_Y        = 32,
  parameter int MAX_Y        = 380,
  parameter int MAX_SPEED    = 8,
  parameter int ACCEL_FRAMES = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               upKey,
  input  logic               downKey,
  input  logic               freeze,
  output logic signed [10:0] topLeftY,
  output logic [3:0]         speed,
  output logic               moving,
  output logic               atLimit
);

  import rod_ctrl_pkg::*;

  localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  localparam logic signed [10:0] INIT_Y11 = INIT_Y[10:0];
  localparam logic signed [10:0] MIN_Y11  = MIN_Y[10:0];
  localparam logic signed [10:0] MAX_Y11  = MAX_Y[10:0];
  localparam logic signed [11:0] MIN_Y12  = MIN_Y[11:0];
  localparam logic signed [11:0] MAX_Y12  = MAX_Y[11:0];

  localparam logic [SPEED_W-1:0] SPD_MAX  = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] SPD_ONE  = SPEED_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  localparam logic AT_LIMIT_INIT = (INIT_Y == MIN_Y) || (INIT_Y == MAX_Y);

  rod_state_t         state, state_n;
  logic [SPEED_W-1:0] speed_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               dir_up, dir_up_n;
  logic signed [10:0] y_n;
  logic               at_limit_n;
  logic               key_up, key_dn, same_key;
  logic               move;
  logic signed [11:0] step, y_wide;
  clamp_t             clamped;

  // Conflicting keys cancel so both-held behaves like no key.
  assign key_up = upKey & ~downKey;
  assign key_dn = downKey & ~upKey;

  // Next-state, speed, accel counter and clamped position for the coming tick.
  always_comb begin
    state_n    = state;
    speed_n    = speed;
    cnt_n      = cnt;
    dir_up_n   = dir_up;
    y_n        = topLeftY;
    move       = 1'b0;
    same_key   = dir_up ? key_up : key_dn;
    step       = '0;
    y_wide     = '0;
    clamped    = '0;

    if (freeze) begin
      state_n = IDLE;
      speed_n = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_up && topLeftY != MIN_Y11) begin
            state_n  = UP;
            speed_n  = SPD_ONE;
            cnt_n    = '0;
            dir_up_n = 1'b1;
            move     = 1'b1;
          end else if (key_dn && topLeftY != MAX_Y11) begin
            state_n  = DOWN;
            speed_n  = SPD_ONE;
            cnt_n    = '0;
            dir_up_n = 1'b0;
            move     = 1'b1;
          end
        end
        UP, DOWN: begin
          move = 1'b1;
          if ((state == UP) ? key_up : key_dn) begin
            if (cnt == CNT_LAST) begin
              speed_n = (speed >= SPD_MAX) ? SPD_MAX : speed + SPD_ONE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CNT_ONE;
            end
          end else begin
            // Releasing at speed 1 lands directly in IDLE rather than a zero-speed BRAKE.
            speed_n = speed - SPD_ONE;
            cnt_n   = '0;
            state_n = (speed_n == '0) ? IDLE : BRAKE;
          end
        end
        BRAKE: begin
          move = 1'b1;
          if (same_key) begin
            state_n = dir_up ? UP : DOWN;
            cnt_n   = '0;
          end else begin
            speed_n = speed - SPD_ONE;
            if (speed_n == '0) state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          speed_n = '0;
          cnt_n   = '0;
        end
      endcase

      if (move) begin
        step    = $signed({{(12 - SPEED_W){1'b0}}, speed_n});
        y_wide  = dir_up_n ? ($signed({topLeftY[10], topLeftY}) - step)
                           : ($signed({topLeftY[10], topLeftY}) + step);
        clamped = clamp_y(y_wide, MIN_Y12, MAX_Y12);
        y_n     = clamped.y;
        if (clamped.hit) begin
          state_n = IDLE;
          speed_n = '0;
          cnt_n   = '0;
        end
      end
    end

    at_limit_n = (y_n == MIN_Y11) || (y_n == MAX_Y11);
  end

  // Commit all state and registered outputs only on the start-of-frame tick.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      speed    <= '0;
      cnt      <= '0;
      dir_up   <= 1'b0;
      topLeftY <= INIT_Y11;
      moving   <= 1'b0;
      atLimit  <= AT_LIMIT_INIT;
    end else if (startOfFrame) begin
      state    <= state_n;
      speed    <= speed_n;
      cnt      <= cnt_n;
      dir_up   <= dir_up_n;
      topLeftY <= y_n;
      moving   <= (state_n != IDLE);
      atLimit  <= at_limit_n;
    end
  end

endmodule

// File: tb/tb_rod_motion_ctrl.sv
// tb/tb_rod_motion_ctrl.sv - directed self-checking bench for rod_motion_ctrl
module tb_rod_motion_ctrl;

  logic               clk;
  logic               resetN;
  logic               startOfFrame;
  logic               upKey;
  logic               downKey;
  logic               freeze;
  logic signed [10:0] topLeftY, lim_topLeftY;
  logic [3:0]         speed, lim_speed;
  logic               moving, lim_moving;
  logic               atLimit, lim_atLimit;

  int checks   = 0;
  int failures = 0;

  rod_motion_ctrl u_dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .upKey        (upKey),
    .downKey      (downKey),
    .freeze       (freeze),
    .topLeftY     (topLeftY),
    .speed        (speed),
    .moving       (moving),
    .atLimit      (atLimit)
  );

  rod_motion_ctrl #(.MIN_Y(195)) u_lim (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .upKey        (upKey),
    .downKey      (downKey),
    .freeze       (freeze),
    .topLeftY     (lim_topLeftY),
    .speed        (lim_speed),
    .moving       (lim_moving),
    .atLimit      (lim_atLimit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // One frame: keys valid during the startOfFrame cycle, then idle cycles; returns at a negedge.
  task automatic tick(input logic up, input logic dn, input logic frz);
    @(negedge clk);
    upKey        = up;
    downKey      = dn;
    freeze       = frz;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    upKey        = 1'b0;
    downKey      = 1'b0;
    freeze       = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int exp_spd_up [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
  int exp_lim_y  [12] = '{199, 198, 197, 196, 195, 195, 195, 195, 195, 195, 195, 195};
  int exp_brk_spd[3]  = '{2, 1, 0};
  int exp_brk_y  [3]  = '{174, 173, 173};
  int y_model;

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    upKey        = 1'b0;
    downKey      = 1'b0;
    freeze       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_y", topLeftY, 200);
    check("rst_speed", speed, 0);
    check("rst_moving", moving, 0);
    check("rst_atlimit", atLimit, 0);
    check("rst_lim_atlimit", lim_atLimit, 0);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      check("nokey_y", topLeftY, 200);
      check("nokey_moving", moving, 0);
    end

    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      check("both_y", topLeftY, 200);
      check("both_moving", moving, 0);
    end

    y_model = 200;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      y_model = y_model - exp_spd_up[i];
      check("up_speed", speed, exp_spd_up[i]);
      check("up_y", topLeftY, y_model);
      check("lim_y", lim_topLeftY, exp_lim_y[i]);
      if (i >= 4) begin
        check("lim_speed", lim_speed, 0);
        check("lim_moving", lim_moving, 0);
        check("lim_atlimit", lim_atLimit, 1);
      end else begin
        check("lim_atlimit_pre", lim_atLimit, 0);
      end
    end
    check("up_final_y", topLeftY, 176);
    check("up_moving", moving, 1);

    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      check("brake_speed", speed, exp_brk_spd[i]);
      check("brake_y", topLeftY, exp_brk_y[i]);
    end
    check("brake_moving", moving, 0);

    // Climb back to speed 3: 4 ticks at 1, 4 at 2, 1 at 3.
    for (int i = 0; i < 9; i++) tick(1'b1, 1'b0, 1'b0);
    check("pre_freeze_speed", speed, 3);
    check("pre_freeze_y", topLeftY, 158);
    tick(1'b1, 1'b0, 1'b1);
    check("freeze_y", topLeftY, 158);
    check("freeze_speed", speed, 0);
    check("freeze_moving", moving, 0);
    tick(1'b1, 1'b0, 1'b1);
    check("freeze_hold_y", topLeftY, 158);
    check("freeze_hold_moving", moving, 0);
    tick(1'b1, 1'b0, 1'b0);
    check("unfreeze_y", topLeftY, 157);
    check("unfreeze_speed", speed, 1);

    tick(1'b0, 1'b0, 1'b0);
    check("stop_speed", speed, 0);
    check("stop_moving", moving, 0);
    check("stop_y", topLeftY, 157);

    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0);
    check("down_speed", speed, 2);
    check("down_y", topLeftY, 163);
    check("down_moving", moving, 1);

    #2 resetN = 1'b0;
    #1;
    check("async_rst_y", topLeftY, 200);
    check("async_rst_speed", speed, 0);
    check("async_rst_moving", moving, 0);
    @(negedge clk);
    resetN = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    check("post_rst_y", topLeftY, 200);
    tick(1'b0, 1'b1, 1'b0);
    check("post_rst_down_y", topLeftY, 201);
    check("post_rst_down_speed", speed, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rod_motion_ctrl.md
# rod_motion_ctrl

Per-frame vertical motion controller for one foosball rod sprite. Samples player up/down keys on each start-of-frame pulse and runs an accelerate/brake state machine. Produces the registered `topLeftY` that drives the rod's rectangle-drawing object; X stays fixed in that object. One instance per rod, placed between the keypad decoder and the rod drawing objects.

## Interface
- `INIT_Y`, 200: `topLeftY` after reset.
- `MIN_Y`, 32: smallest legal `topLeftY`, the top limit.
- `MAX_Y`, 380: largest legal `topLeftY`, the bottom limit. Equals screen bottom minus object height.
- `MAX_SPEED`, 8: maximum pixels moved per frame. Range 1..15.
- `ACCEL_FRAMES`, 4: number of frames held at each speed step before speed increments. Must be ≥1.

- `clk`, in, 1: system clock.
- `resetN`, in, 1: reset, asynchronous, active-low.
- `startOfFrame`, in, 1: one-cycle pulse per VGA frame. This is the only update instant.
- `upKey`, in, 1: level, player requests upward motion (decreasing Y).
- `downKey`, in, 1: level, player requests downward motion.
- `freeze`, in, 1: level, game paused or goal sequence. Stops motion.
- `topLeftY`, out, signed 11: registered rod top-left Y.
- `speed`, out, 4: registered current speed in pixels/frame.
- `moving`, out, 1: registered, high when state ≠ IDLE.
- `atLimit`, out, 1: registered, high when `topLeftY` equals `MIN_Y` or `MAX_Y`.

## Operation
- FSM states: IDLE, UP, DOWN, BRAKE. A direction register `dirUp` is held through BRAKE.
- All state changes happen only on a clock edge where `startOfFrame`=1, called a tick. Between ticks every register holds.
- Key decode at a tick:
  - up = `upKey` & !`downKey`.
  - down = `downKey` & !`upKey`.
  - Both keys pressed, or neither, counts as no key.
- `freeze`=1 at a tick overrides everything: state→IDLE, speed→0, accel counter→0, Y unchanged.
- IDLE:
  - up → UP, speed 1, cnt 0, `dirUp`=1.
  - down → DOWN, speed 1, cnt 0, `dirUp`=0.
  - Exception: up while Y=`MIN_Y`, or down while Y=`MAX_Y`, stays IDLE with no motion.
- UP (DOWN symmetric):
  - Same key held: if cnt = `ACCEL_FRAMES`-1 then speed = min(speed+1, `MAX_SPEED`) and cnt 0; otherwise cnt+1.
  - No key or opposite key → BRAKE, speed−1.
- BRAKE:
  - speed−1 per tick.
  - When the new speed is 0 → IDLE.
  - Same-direction key → UP/DOWN at the current speed, cnt 0.
  - Opposite key is ignored until IDLE is reached.
- Position update at the same tick uses the new speed: Ynext = Y − speed (`dirUp`) or Y + speed. Computed at 12-bit signed width.
- Clamp: if Ynext < `MIN_Y` or Ynext > `MAX_Y`, Y = the limit, speed 0, state IDLE, cnt 0.
- `atLimit` is recomputed from the new Y at every tick and at reset.

## Timing
- Reset values: `topLeftY`=`INIT_Y`, `speed`=0, `moving`=0, state IDLE, cnt 0, `atLimit` = (`INIT_Y`==`MIN_Y` || `INIT_Y`==`MAX_Y`).
- Latency: all outputs are valid on the clock edge after the `startOfFrame` cycle. They are stable for the rest of the frame.
- Keys and `freeze` are sampled only during the `startOfFrame` cycle. Pulses shorter than that cycle and not overlapping it are lost.
- Reset asserted mid-frame or mid-motion forces the reset values immediately (asynchronous). The first tick after release behaves as from IDLE.
- `startOfFrame` held high for several cycles gives one tick per cycle. Upstream must guarantee a one-cycle pulse.

## Structure
- Package `rod_ctrl_pkg` holds:
  - `rod_state_t` enum {IDLE, UP, DOWN, BRAKE}.
  - `SPEED_W`=4.
  - `clamp_y()` function: 12-bit signed in, limits in, returns 11-bit signed Y plus a hit flag.
- Single module. No sub-module; the FSM, accel counter and position register all live in one `always_ff` with combinational next-state logic.

## Test plan
- Reset with defaults → `topLeftY`=200, `speed`=0, `moving`=0, `atLimit`=0. Ticks with no key → no change.
- Hold `upKey` for 12 ticks → speeds 1,1,1,1,2,2,2,2,3,3,3,3 and Y=176. Release → next 3 ticks give speeds 2,1,0, Y=174,173,173, `moving`=0 after the third.
- With `MIN_Y`=195, hold `upKey` → Y 199,198,197,196, then 195 with `atLimit`=1, `speed`=0, IDLE. Further up ticks keep Y=195.
- `upKey` and `downKey` both high for 5 ticks from IDLE → Y stays 200, `moving`=0.
- Moving up at speed 3, assert `freeze` at a tick → Y unchanged at that tick, `speed`=0, `moving`=0. Keys ignored while `freeze`=1.
- Moving down at speed 2, pull `resetN` low mid-frame → Y=200 and `speed`=0 before the next clock edge.
